// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster bus between the timing generator and its
// pixel source / DAC side. master = generator, slave = consumer/feeder.
interface vga_timing_gen_if #(
   parameter int CBITS = 4
);
   logic [1:0]         mode;
   logic [3*CBITS-1:0] ext_rgb;
   logic [15:0]        x;
   logic [15:0]        y;
   logic               pix_tick;
   logic               hsync;
   logic               vsync;
   logic               de;
   logic [CBITS-1:0]   red;
   logic [CBITS-1:0]   green;
   logic [CBITS-1:0]   blue;
   logic               frame_start;

   modport master (
      input  mode, ext_rgb,
      output x, y, pix_tick, hsync, vsync, de,
      output red, green, blue, frame_start
   );

   modport slave (
      output mode, ext_rgb,
      input  x, y, pix_tick, hsync, vsync, de,
      input  red, green, blue, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing, sync polarity, pixel divider and
// test patterns; sync/de/rgb are registered one clk behind x/y/div.
module vga_timing_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int H_SYNC_POL = 0,
   parameter int V_SYNC_POL = 0,
   parameter int PIX_DIV    = 1,
   parameter int CBITS      = 4
) (
   input  logic             clk,
   input  logic             reset,
   vga_timing_gen_if.master bus
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_BEG  = H_ACTIVE + H_FP;
   localparam int HS_END  = HS_BEG + H_SYNC - 1;
   localparam int VS_BEG  = V_ACTIVE + V_FP;
   localparam int VS_END  = VS_BEG + V_SYNC - 1;
   localparam int BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
   localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   localparam logic [15:0]   H_LAST  = 16'(H_TOTAL - 1);
   localparam logic [15:0]   V_LAST  = 16'(V_TOTAL - 1);
   localparam logic [15:0]   BAR_LST = 16'(BAR_W - 1);
   localparam logic [DW-1:0] DIV_LST = DW'(PIX_DIV - 1);
   localparam logic          HS_ON   = 1'(H_SYNC_POL);
   localparam logic          VS_ON   = 1'(V_SYNC_POL);

   localparam logic [CBITS-1:0] ONES = '1;
   localparam logic [CBITS-1:0] ZERO = '0;

   if (PIX_DIV < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
       H_ACTIVE < 8 || V_ACTIVE < 1 || (H_ACTIVE % 8) != 0 ||
       H_TOTAL > 65535 || V_TOTAL > 65535) begin : g_bad_cfg
      $error("vga_timing_gen: illegal timing parameters");
   end

   logic [DW-1:0]      div;
   logic [15:0]        x;
   logic [15:0]        y;
   logic [3:0]         xm;
   logic [3:0]         ym;
   logic [15:0]        bcnt;
   logic [2:0]         bar;
   logic [1:0]         mode_q;
   logic [1:0]         mode_eff;
   logic               tick;
   logic               h_end;
   logic               v_end;
   logic               at_origin;
   logic               active;
   logic               hs_win;
   logic               vs_win;
   logic [3*CBITS-1:0] rgb;

   logic               hs_q;
   logic               vs_q;
   logic               de_q;
   logic               fs_q;
   logic [3*CBITS-1:0] rgb_q;

   assign tick      = (div == DIV_LST);
   assign h_end     = (x == H_LAST);
   assign v_end     = (y == V_LAST);
   assign at_origin = (x == '0) && (y == '0) && (div == '0);
   assign active    = (x < 16'(H_ACTIVE)) && (y < 16'(V_ACTIVE));
   assign hs_win    = (x >= 16'(HS_BEG)) && (x <= 16'(HS_END));
   assign vs_win    = (y >= 16'(VS_BEG)) && (y <= 16'(VS_END));

   // The frame boundary pixel already uses the newly sampled mode.
   assign mode_eff  = at_origin ? bus.mode : mode_q;

   // Pixel divider, raster counters and running mod-10 / bar counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         div  <= '0;
         x    <= '0;
         y    <= '0;
         xm   <= '0;
         ym   <= '0;
         bcnt <= '0;
         bar  <= '0;
      end else begin
         div <= tick ? '0 : div + DW'(1);
         if (tick) begin
            if (h_end) begin
               x    <= '0;
               xm   <= '0;
               bcnt <= '0;
               bar  <= '0;
               if (v_end) begin
                  y  <= '0;
                  ym <= '0;
               end else begin
                  y  <= y + 16'd1;
                  ym <= (ym == 4'd9) ? 4'd0 : ym + 4'd1;
               end
            end else begin
               x  <= x + 16'd1;
               xm <= (xm == 4'd9) ? 4'd0 : xm + 4'd1;
               if (bcnt == BAR_LST) begin
                  bcnt <= '0;
                  bar  <= bar + 3'd1;
               end else begin
                  bcnt <= bcnt + 16'd1;
               end
            end
         end
      end
   end

   // Mode is only taken at the frame boundary so a frame never tears.
   always_ff @(posedge clk) begin
      if (reset || at_origin) begin
         mode_q <= bus.mode;
      end
   end

   // Pattern select for the current raster position.
   always_comb begin
      rgb = '0;
      unique case (mode_eff)
         2'd0: rgb = bus.ext_rgb;
         2'd1: rgb = (xm == 4'd0 || ym == 4'd0) ?
                     {ONES, ZERO, ZERO} : {ZERO, ZERO, ONES};
         2'd2: rgb = {{CBITS{~bar[2]}},
                      {CBITS{~bar[1]}},
                      {CBITS{~bar[0]}}};
         2'd3: rgb = '0;
      endcase
      if (!active) begin
         rgb = '0;
      end
   end

   // Single output register stage toward the DAC pins.
   always_ff @(posedge clk) begin
      if (reset) begin
         hs_q  <= ~HS_ON;
         vs_q  <= ~VS_ON;
         de_q  <= 1'b0;
         fs_q  <= 1'b0;
         rgb_q <= '0;
      end else begin
         hs_q  <= hs_win ? HS_ON : ~HS_ON;
         vs_q  <= vs_win ? VS_ON : ~VS_ON;
         de_q  <= active;
         fs_q  <= at_origin;
         rgb_q <= rgb;
      end
   end

   assign bus.x           = x;
   assign bus.y           = y;
   assign bus.pix_tick    = tick;
   assign bus.hsync       = hs_q;
   assign bus.vsync       = vs_q;
   assign bus.de          = de_q;
   assign bus.frame_start = fs_q;
   assign bus.red         = rgb_q[3*CBITS-1:2*CBITS];
   assign bus.green       = rgb_q[2*CBITS-1:CBITS];
   assign bus.blue        = rgb_q[CBITS-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three generator configurations against a raster
// model computed from elapsed clocks since reset.
module tb_vga_timing_gen;

   typedef struct {
      int ha, hfp, hs, hbp;
      int va, vfp, vs, vbp;
      int hpol, vpol, pd;
   } cfg_t;

   typedef struct {
      logic        hs, vs, de, fs;
      logic [11:0] rgb;
   } out_t;

   localparam int NCYC = 2600;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic        rst_d  [3];
   logic [1:0]  mode_d [3];
   logic [11:0] ext_d  [3];

   logic [15:0] ox  [3];
   logic [15:0] oy  [3];
   logic        otk [3];
   logic        ohs [3];
   logic        ovs [3];
   logic        ode [3];
   logic        ofs [3];
   logic [11:0] orgb[3];

   vga_timing_gen_if #(.CBITS(4)) b0 ();
   vga_timing_gen_if #(.CBITS(4)) b1 ();
   vga_timing_gen_if #(.CBITS(4)) b2 ();

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_SYNC_POL(0), .V_SYNC_POL(0), .PIX_DIV(1), .CBITS(4)
   ) u0 (.clk(clk), .reset(rst_d[0]), .bus(b0));

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_SYNC_POL(1), .V_SYNC_POL(1), .PIX_DIV(3), .CBITS(4)
   ) u1 (.clk(clk), .reset(rst_d[1]), .bus(b1));

   vga_timing_gen #(.CBITS(4)) u2 (
      .clk(clk), .reset(rst_d[2]), .bus(b2)
   );

   assign b0.mode = mode_d[0];
   assign b1.mode = mode_d[1];
   assign b2.mode = mode_d[2];
   assign b0.ext_rgb = ext_d[0];
   assign b1.ext_rgb = ext_d[1];
   assign b2.ext_rgb = ext_d[2];

   assign ox[0] = b0.x;  assign ox[1] = b1.x;  assign ox[2] = b2.x;
   assign oy[0] = b0.y;  assign oy[1] = b1.y;  assign oy[2] = b2.y;
   assign otk[0] = b0.pix_tick;
   assign otk[1] = b1.pix_tick;
   assign otk[2] = b2.pix_tick;
   assign ohs[0] = b0.hsync; assign ohs[1] = b1.hsync; assign ohs[2] = b2.hsync;
   assign ovs[0] = b0.vsync; assign ovs[1] = b1.vsync; assign ovs[2] = b2.vsync;
   assign ode[0] = b0.de;    assign ode[1] = b1.de;    assign ode[2] = b2.de;
   assign ofs[0] = b0.frame_start;
   assign ofs[1] = b1.frame_start;
   assign ofs[2] = b2.frame_start;
   assign orgb[0] = {b0.red, b0.green, b0.blue};
   assign orgb[1] = {b1.red, b1.green, b1.blue};
   assign orgb[2] = {b2.red, b2.green, b2.blue};

   task automatic chk(input int inst, input string tag,
                      input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL u%0d %s cyc=%0d got=%h exp=%h",
                  inst, tag, cyc, got, exp);
      end
   endtask

   // Raster position reached n clocks after reset release.
   function automatic void pos_of(input cfg_t c, input int n,
                                  output int px, output int py,
                                  output int pd);
      int ht;
      int vt;
      int p;
      ht = c.ha + c.hfp + c.hs + c.hbp;
      vt = c.va + c.vfp + c.vs + c.vbp;
      p  = n / c.pd;
      pd = n % c.pd;
      px = p % ht;
      py = (p / ht) % vt;
   endfunction

   function automatic out_t reset_out(input cfg_t c);
      out_t o;
      o.hs  = (c.hpol == 0);
      o.vs  = (c.vpol == 0);
      o.de  = 1'b0;
      o.fs  = 1'b0;
      o.rgb = '0;
      return o;
   endfunction

   function automatic out_t out_of(input cfg_t c, input int px,
                                   input int py, input int pd,
                                   input logic [1:0] m,
                                   input logic [11:0] ext);
      out_t o;
      int   bi;
      logic act;
      logic hw;
      logic vw;
      act = (px < c.ha) && (py < c.va);
      hw  = (px >= c.ha + c.hfp) && (px < c.ha + c.hfp + c.hs);
      vw  = (py >= c.va + c.vfp) && (py < c.va + c.vfp + c.vs);
      o.hs = hw ? (c.hpol != 0) : (c.hpol == 0);
      o.vs = vw ? (c.vpol != 0) : (c.vpol == 0);
      o.de = act;
      o.fs = (px == 0) && (py == 0) && (pd == 0);
      case (m)
         2'd0: o.rgb = ext;
         2'd1: o.rgb = (px % 10 == 0 || py % 10 == 0) ? 12'hF00 : 12'h00F;
         2'd2: begin
            bi = 7 - px / (c.ha / 8);
            o.rgb = {bi[2] ? 4'hF : 4'h0,
                     bi[1] ? 4'hF : 4'h0,
                     bi[0] ? 4'hF : 4'h0};
         end
         default: o.rgb = '0;
      endcase
      if (!act) o.rgb = '0;
      return o;
   endfunction

   cfg_t       cfg   [3];
   int         cnt   [3];
   logic [1:0] fmode [3];
   out_t       eo    [3];
   int         ppx   [3];
   int         ppy   [3];
   logic       pvld  [3];
   int         lastfs[3];

   initial begin
      int px, py, pd;
      cfg[0] = '{8, 2, 3, 1, 4, 1, 2, 1, 0, 0, 1};
      cfg[1] = '{8, 2, 3, 1, 4, 1, 2, 1, 1, 1, 3};
      cfg[2] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 1};
      for (int i = 0; i < 3; i++) begin
         rst_d[i]  = 1'b1;
         mode_d[i] = 2'd1;
         ext_d[i]  = '0;
         cnt[i]    = 0;
         fmode[i]  = 2'd1;
         pvld[i]   = 1'b0;
         lastfs[i] = -1;
         ppx[i]    = 0;
         ppy[i]    = 0;
      end
      mode_d[1] = 2'(($urandom) % 4);

      for (int c = 0; c < NCYC; c++) begin
         @(posedge clk);
         cyc = c;
         for (int i = 0; i < 3; i++) begin
            if (rst_d[i]) begin
               eo[i]     = reset_out(cfg[i]);
               fmode[i]  = mode_d[i];
               cnt[i]    = 0;
               pvld[i]   = 1'b0;
               lastfs[i] = -1;
            end else begin
               pos_of(cfg[i], cnt[i], px, py, pd);
               if (px == 0 && py == 0 && pd == 0) fmode[i] = mode_d[i];
               eo[i]   = out_of(cfg[i], px, py, pd, fmode[i], ext_d[i]);
               ppx[i]  = px;
               ppy[i]  = py;
               pvld[i] = 1'b1;
               cnt[i]++;
            end
         end
         #1;
         for (int i = 0; i < 3; i++) begin
            pos_of(cfg[i], cnt[i], px, py, pd);
            chk(i, "x", 32'(ox[i]), 32'(px));
            chk(i, "y", 32'(oy[i]), 32'(py));
            chk(i, "pix_tick", 32'(otk[i]), 32'(pd == cfg[i].pd - 1));
            chk(i, "hsync", 32'(ohs[i]), 32'(eo[i].hs));
            chk(i, "vsync", 32'(ovs[i]), 32'(eo[i].vs));
            chk(i, "de", 32'(ode[i]), 32'(eo[i].de));
            chk(i, "frame_start", 32'(ofs[i]), 32'(eo[i].fs));
            chk(i, "rgb", 32'(orgb[i]), 32'(eo[i].rgb));
            if (i < 2 && ofs[i] === 1'b1) begin
               if (lastfs[i] >= 0)
                  chk(i, "fs_period", 32'(c - lastfs[i]),
                      32'(i == 0 ? 112 : 336));
               lastfs[i] = c;
            end
         end
         if (pvld[2] && fmode[2] == 2'd1) begin
            if (ppx[2] == 0 && ppy[2] == 0)
               chk(2, "grid_0_0", 32'(orgb[2]), 32'h0F00);
            if (ppx[2] == 1 && ppy[2] == 1)
               chk(2, "grid_1_1", 32'(orgb[2]), 32'h000F);
            if (ppx[2] == 10 && ppy[2] == 3)
               chk(2, "grid_10_3", 32'(orgb[2]), 32'h0F00);
         end
         if (pvld[0] && fmode[0] == 2'd2 && ppy[0] == 0) begin
            if (ppx[0] == 0)
               chk(0, "bar_x0", 32'(orgb[0]), 32'h0FFF);
            if (ppx[0] == 7)
               chk(0, "bar_x7", 32'(orgb[0]), 32'h0000);
         end

         rst_d[0] = (c < 2) || (cnt[0] == 112 * 4 + 14 + 5);
         rst_d[1] = (c < 2) || ($urandom_range(0, 499) == 0);
         rst_d[2] = (c < 2);
         if (cnt[0] < 30)
            mode_d[0] = 2'd1;
         else if (cnt[0] < 336)
            mode_d[0] = 2'd2;
         else if ($urandom_range(0, 15) == 0)
            mode_d[0] = 2'(($urandom) % 4);
         if ($urandom_range(0, 15) == 0)
            mode_d[1] = 2'(($urandom) % 4);
         mode_d[2] = 2'd1;
         for (int i = 0; i < 3; i++) ext_d[i] = 12'($urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
